// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the serial transmitter and receiver.
package uart_pkg;

    localparam int FRAME_BITS = 10;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a selectable reset level.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: mid-bit sampling off a falling start edge, with a running sum of good bytes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int clocks_per_bit = 4
) (
    input  logic        ser_clk,
    input  logic        rst_n,
    input  logic        SER_RX,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_frame_err,
    output logic        rx_busy,
    output logic [31:0] rx_sum
);

    localparam int TW = $clog2(clocks_per_bit);
    localparam int H  = clocks_per_bit / 2;
    // Timer counts down to zero, so a load of N-1 lands the sample N cycles later.
    localparam logic [TW-1:0] T_HALF = TW'(H - 1);
    localparam logic [TW-1:0] T_BIT  = TW'(clocks_per_bit - 1);

    logic rx_s;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk_i  (ser_clk),
        .rst_ni (rst_n),
        .d_i    (SER_RX),
        .q_o    (rx_s)
    );

    rx_state_t       state_q,  state_d;
    logic [TW-1:0]   timer_q,  timer_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shreg_q,  shreg_d;
    logic [7:0]      data_q,   data_d;
    logic            valid_q,  valid_d;
    logic            ferr_q,   ferr_d;
    logic [31:0]     sum_q,    sum_d;

    logic tick;
    assign tick = (timer_q == '0);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        sum_d    = sum_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_d  = RX_START;
                    timer_d  = T_HALF;
                    bitcnt_d = 4'd0;
                end
            end
            RX_START: begin
                if (!tick) begin
                    timer_d = timer_q - 1'b1;
                end else if (rx_s) begin
                    state_d = RX_IDLE;
                end else begin
                    state_d  = RX_DATA;
                    timer_d  = T_BIT;
                    bitcnt_d = 4'd0;
                end
            end
            RX_DATA: begin
                if (!tick) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    shreg_d  = {rx_s, shreg_q[7:1]};
                    timer_d  = T_BIT;
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (!tick) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (rx_s) begin
                        valid_d = 1'b1;
                        data_d  = shreg_q;
                        sum_d   = sum_q + {24'd0, shreg_q};
                        state_d = RX_IDLE;
                    end else begin
                        // Stay out of IDLE until the line recovers, so a stuck-low line reports once.
                        ferr_d  = 1'b1;
                        state_d = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_s) state_d = RX_IDLE;
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge ser_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RX_IDLE;
            timer_q  <= '0;
            bitcnt_q <= 4'd0;
            shreg_q  <= 8'd0;
            data_q   <= 8'd0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            sum_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            sum_q    <= sum_d;
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_busy      = (state_q != RX_IDLE);
    assign rx_sum       = sum_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a behavioural 8N1 sender drives the line, a scoreboard tracks expected bytes and sum.
module tb_uart_rx;

    localparam int C = 4;
    localparam int H = C / 2;

    logic        ser_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        SER_RX  = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_frame_err;
    logic        rx_busy;
    logic [31:0] rx_sum;

    uart_rx #(.clocks_per_bit(C)) dut (
        .ser_clk      (ser_clk),
        .rst_n        (rst_n),
        .SER_RX       (SER_RX),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy),
        .rx_sum       (rx_sum)
    );

    always #5 ser_clk = ~ser_clk;

    int checks = 0;
    int passed = 0;

    logic [7:0]  exp_q[$];
    logic [31:0] exp_sum  = 32'd0;
    logic [7:0]  exp_data = 8'd0;

    logic [7:0] got_q[$];
    int err_cnt = 0;
    int viol    = 0;
    int busy_cyc = 0;
    logic pv = 1'b0;
    logic pe = 1'b0;

    // Output monitor, sampled on the falling edge away from state updates.
    always @(negedge ser_clk) begin
        if (rx_valid) got_q.push_back(rx_data);
        if (rx_frame_err) err_cnt++;
        if ((rx_valid && rx_frame_err) || (rx_valid && pv) || (rx_frame_err && pe)) viol++;
        if (rx_busy) busy_cyc++;
        pv = rx_valid;
        pe = rx_frame_err;
    end

    task automatic drive_bit(input logic v);
        SER_RX = v;
        repeat (C) @(posedge ser_clk);
        #1;
    endtask

    task automatic idle(input int n);
        SER_RX = 1'b1;
        repeat (n) begin
            @(posedge ser_clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopv);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stopv);
        SER_RX = 1'b1;
        if (stopv) begin
            exp_q.push_back(b);
            exp_sum  = exp_sum + {24'd0, b};
            exp_data = b;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge ser_clk);
        #1;
        checks++; if (rx_data !== 8'd0) $display("FAIL reset_data got %h exp 00", rx_data); else passed++;
        checks++; if (rx_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", rx_valid); else passed++;
        checks++; if (rx_frame_err !== 1'b0) $display("FAIL reset_ferr got %b exp 0", rx_frame_err); else passed++;
        checks++; if (rx_busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", rx_busy); else passed++;
        checks++; if (rx_sum !== 32'd0) $display("FAIL reset_sum got %h exp 0", rx_sum); else passed++;
        #3 rst_n = 1'b1;
        idle(10);
        checks++; if (got_q.size() !== 0) $display("FAIL reset_no_pulse got %0d exp 0", got_q.size()); else passed++;
    endtask

    task automatic test_basic();
        int n0 = got_q.size();
        send_frame(8'h55, 1'b1);
        idle(12);
        checks++; if (got_q.size() !== n0 + 1) $display("FAIL basic_count got %0d exp %0d", got_q.size(), n0 + 1); else passed++;
        checks++; if (rx_data !== 8'h55) $display("FAIL basic_data got %h exp 55", rx_data); else passed++;
        checks++; if (rx_sum !== exp_sum) $display("FAIL basic_sum got %h exp %h", rx_sum, exp_sum); else passed++;
        checks++; if (rx_busy !== 1'b0) $display("FAIL basic_busy got %b exp 0", rx_busy); else passed++;
    endtask

    task automatic test_back_to_back();
        int n0 = got_q.size();
        int e0 = err_cnt;
        logic [7:0] pat [3] = '{8'h00, 8'hFF, 8'hA5};
        for (int i = 0; i < 3; i++) send_frame(pat[i], 1'b1);
        idle(12);
        checks++; if (got_q.size() !== n0 + 3) $display("FAIL b2b_count got %0d exp %0d", got_q.size(), n0 + 3); else passed++;
        for (int i = 0; i < 3; i++) begin
            if (n0 + i < got_q.size()) begin
                checks++;
                if (got_q[n0+i] !== pat[i]) $display("FAIL b2b_byte%0d got %h exp %h", i, got_q[n0+i], pat[i]); else passed++;
            end
        end
        checks++; if (rx_sum !== exp_sum) $display("FAIL b2b_sum got %h exp %h", rx_sum, exp_sum); else passed++;
        checks++; if (err_cnt !== e0) $display("FAIL b2b_ferr got %0d exp %0d", err_cnt, e0); else passed++;
    endtask

    task automatic test_glitch();
        int n0 = got_q.size();
        int e0 = err_cnt;
        int b0 = busy_cyc;
        SER_RX = 1'b0;
        @(posedge ser_clk);
        #1;
        idle(12);
        checks++; if (busy_cyc - b0 !== H) $display("FAIL glitch_busy_cycles got %0d exp %0d", busy_cyc - b0, H); else passed++;
        checks++; if (got_q.size() !== n0) $display("FAIL glitch_valid got %0d exp %0d", got_q.size(), n0); else passed++;
        checks++; if (err_cnt !== e0) $display("FAIL glitch_ferr got %0d exp %0d", err_cnt, e0); else passed++;
        checks++; if (rx_busy !== 1'b0) $display("FAIL glitch_idle got %b exp 0", rx_busy); else passed++;
    endtask

    task automatic test_frame_err();
        int n0 = got_q.size();
        int e0 = err_cnt;
        send_frame(8'h3C, 1'b0);
        idle(12);
        checks++; if (err_cnt !== e0 + 1) $display("FAIL ferr_count got %0d exp %0d", err_cnt, e0 + 1); else passed++;
        checks++; if (got_q.size() !== n0) $display("FAIL ferr_no_valid got %0d exp %0d", got_q.size(), n0); else passed++;
        checks++; if (rx_data !== exp_data) $display("FAIL ferr_data got %h exp %h", rx_data, exp_data); else passed++;
        checks++; if (rx_sum !== exp_sum) $display("FAIL ferr_sum got %h exp %h", rx_sum, exp_sum); else passed++;
        SER_RX = 1'b0;
        repeat (80) @(posedge ser_clk);
        #1;
        idle(12);
        checks++; if (err_cnt !== e0 + 2) $display("FAIL ferr_held_low got %0d exp %0d", err_cnt, e0 + 2); else passed++;
        send_frame(8'h01, 1'b1);
        idle(12);
        checks++; if (got_q.size() !== n0 + 1) $display("FAIL ferr_recover_count got %0d exp %0d", got_q.size(), n0 + 1); else passed++;
        checks++; if (rx_data !== 8'h01) $display("FAIL ferr_recover_data got %h exp 01", rx_data); else passed++;
        checks++; if (rx_sum !== exp_sum) $display("FAIL ferr_recover_sum got %h exp %h", rx_sum, exp_sum); else passed++;
    endtask

    task automatic test_mid_reset();
        logic [7:0] b = 8'h81;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        SER_RX = b[4];
        repeat (2) @(posedge ser_clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rx_busy !== 1'b0) $display("FAIL mrst_busy got %b exp 0", rx_busy); else passed++;
        checks++; if (rx_data !== 8'd0) $display("FAIL mrst_data got %h exp 00", rx_data); else passed++;
        checks++; if (rx_sum !== 32'd0) $display("FAIL mrst_sum got %h exp 0", rx_sum); else passed++;
        checks++; if (rx_valid !== 1'b0 || rx_frame_err !== 1'b0) $display("FAIL mrst_pulses got %b%b exp 00", rx_valid, rx_frame_err); else passed++;
        exp_sum  = 32'd0;
        exp_data = 8'd0;
        SER_RX = 1'b1;
        repeat (3) @(posedge ser_clk);
        #1 rst_n = 1'b1;
        idle(10);
        send_frame(8'h7E, 1'b1);
        idle(12);
        checks++; if (rx_data !== 8'h7E) $display("FAIL mrst_next_data got %h exp 7e", rx_data); else passed++;
        checks++; if (rx_sum !== 32'h7E) $display("FAIL mrst_next_sum got %h exp 0000007e", rx_sum); else passed++;
    endtask

    task automatic test_latency();
        int first = 0;
        logic [7:0] b = 8'($urandom);
        idle(5);
        fork
            send_frame(b, 1'b1);
            begin
                for (int k = 1; k <= 60; k++) begin
                    @(posedge ser_clk);
                    #1;
                    if (rx_valid && first == 0) first = k;
                end
            end
        join
        idle(5);
        checks++; if (first !== 2 + H + 9 * C + 1) $display("FAIL latency got %0d exp %0d", first, 2 + H + 9 * C + 1); else passed++;
        checks++; if (rx_data !== b) $display("FAIL latency_data got %h exp %h", rx_data, b); else passed++;
    endtask

    task automatic test_random();
        int n0 = got_q.size();
        int e0 = err_cnt;
        int exp_err = 0;
        int q0 = exp_q.size();
        for (int i = 0; i < 24; i++) begin
            logic [7:0] b = 8'($urandom);
            logic good = ($urandom_range(0, 4) != 0);
            send_frame(b, good);
            if (!good) begin
                exp_err++;
                idle(C);
            end else begin
                idle($urandom_range(0, 2));
            end
        end
        idle(15);
        checks++; if (got_q.size() - n0 !== exp_q.size() - q0) $display("FAIL rand_count got %0d exp %0d", got_q.size() - n0, exp_q.size() - q0); else passed++;
        for (int i = 0; i < exp_q.size() - q0; i++) begin
            if (n0 + i < got_q.size()) begin
                checks++;
                if (got_q[n0+i] !== exp_q[q0+i]) $display("FAIL rand_byte%0d got %h exp %h", i, got_q[n0+i], exp_q[q0+i]); else passed++;
            end
        end
        checks++; if (rx_sum !== exp_sum) $display("FAIL rand_sum got %h exp %h", rx_sum, exp_sum); else passed++;
        checks++; if (err_cnt - e0 !== exp_err) $display("FAIL rand_ferr got %0d exp %0d", err_cnt - e0, exp_err); else passed++;
        checks++; if (viol !== 0) $display("FAIL pulse_exclusive got %0d exp 0", viol); else passed++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_mid_reset();
        test_latency();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
